// File: rtl/dbus_router.sv
// Routes single core requests to one of N_SLV slaves by top-nibble segment decode.
// Latency: slave strobe in the accept cycle; completion when the slave answers, 1 cycle for unmapped, TIMEOUT cycles on a silent slave.
// Backpressure: one transaction outstanding; strobes arriving while busy are dropped.
module dbus_router #(
  parameter int                    XLEN     = 32,
  parameter int                    N_SLV    = 4,
  parameter logic [4*N_SLV-1:0]    SEG_BASE = {4'hF, 4'hC, 4'h8, 4'h0},
  parameter logic [4*N_SLV-1:0]    SEG_MASK = {4'hF, 4'hF, 4'hC, 4'hF},
  parameter int                    TIMEOUT  = 255,
  parameter logic [XLEN-1:0]       ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     p_strobe_i,
  input  logic [XLEN-1:0]          p_addr_i,
  input  logic                     p_rw_i,
  input  logic [XLEN/8-1:0]        p_byte_enable_i,
  input  logic [XLEN-1:0]          p_data_i,
  output logic [XLEN-1:0]          p_data_o,
  output logic                     p_ready_o,
  output logic                     p_err_o,
  output logic                     busy_o,
  output logic [N_SLV-1:0]         s_strobe_o,
  output logic [N_SLV-1:0]         s_rw_o,
  output logic [XLEN-1:0]          s_addr_o,
  output logic [XLEN/8-1:0]        s_byte_enable_o,
  output logic [XLEN-1:0]          s_data_o,
  input  logic [N_SLV*XLEN-1:0]    s_data_i,
  input  logic [N_SLV-1:0]         s_ready_i
);

  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t          state;
  logic [SW-1:0]   sel_r;
  logic [15:0]     cnt;

  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic            sel_rdy;
  logic [XLEN-1:0] sel_dat;
  logic            timeout_hit;

  // Address, byte lanes and write data are shared by all slaves.
  assign s_addr_o        = p_addr_i;
  assign s_byte_enable_o = p_byte_enable_i;
  assign s_data_o        = p_data_i;

  // Segment decode; scanning downwards lets the lowest matching slave win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((p_addr_i[XLEN-1:XLEN-4] & SEG_MASK[4*k +: 4]) == SEG_BASE[4*k +: 4]) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  assign sel_rdy     = s_ready_i[sel_r];
  assign sel_dat     = s_data_i[int'(sel_r)*XLEN +: XLEN];
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  // Output decode from current state; everything is held at zero during reset.
  always_comb begin
    s_strobe_o = '0;
    s_rw_o     = '0;
    p_ready_o  = 1'b0;
    p_err_o    = 1'b0;
    p_data_o   = '0;
    busy_o     = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (p_strobe_i && hit) begin
            s_strobe_o[hit_idx] = 1'b1;
            s_rw_o[hit_idx]     = p_rw_i;
          end
        end
        WAIT: begin
          busy_o   = 1'b1;
          p_data_o = sel_dat;
          if (sel_rdy) begin
            // Slave completion takes priority over an expiring timeout.
            p_ready_o = 1'b1;
          end else if (timeout_hit) begin
            p_ready_o = 1'b1;
            p_err_o   = 1'b1;
            p_data_o  = ERR_DATA;
          end
        end
        ERR: begin
          busy_o    = 1'b1;
          p_ready_o = 1'b1;
          p_err_o   = 1'b1;
          p_data_o  = ERR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Transaction state, selected slave and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      sel_r <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p_strobe_i) begin
            if (hit) begin
              sel_r <= hit_idx;
              cnt   <= '0;
              state <= WAIT;
            end else begin
              state <= ERR;
            end
          end
        end
        WAIT: begin
          // The timeout exit fires before the counter could ever wrap.
          if (sel_rdy || timeout_hit) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_router.sv
// Bench for dbus_router: directed scenarios plus randomized transactions.
// Each transaction is checked cycle by cycle against a transaction-level model.
// Drives inputs 1 time unit after the rising edge, samples on the falling edge.
module tb_dbus_router;

  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [3:0] BASE [N] = '{4'h0, 4'h8, 4'hC, 4'hF};
  localparam logic [3:0] MASK [N] = '{4'hF, 4'hC, 4'hF, 4'hF};

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p_strobe_i;
  logic [XLEN-1:0]   p_addr_i;
  logic              p_rw_i;
  logic [XLEN/8-1:0] p_byte_enable_i;
  logic [XLEN-1:0]   p_data_i;
  logic [XLEN-1:0]   p_data_o;
  logic              p_ready_o;
  logic              p_err_o;
  logic              busy_o;
  logic [N-1:0]      s_strobe_o;
  logic [N-1:0]      s_rw_o;
  logic [XLEN-1:0]   s_addr_o;
  logic [XLEN/8-1:0] s_byte_enable_o;
  logic [XLEN-1:0]   s_data_o;
  logic [N*XLEN-1:0] s_data_i;
  logic [N-1:0]      s_ready_i;

  int n_chk  = 0;
  int n_fail = 0;

  dbus_router #(.XLEN(XLEN), .N_SLV(N), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p_strobe_i(p_strobe_i), .p_addr_i(p_addr_i), .p_rw_i(p_rw_i),
    .p_byte_enable_i(p_byte_enable_i), .p_data_i(p_data_i),
    .p_data_o(p_data_o), .p_ready_o(p_ready_o), .p_err_o(p_err_o), .busy_o(busy_o),
    .s_strobe_o(s_strobe_o), .s_rw_o(s_rw_o), .s_addr_o(s_addr_o),
    .s_byte_enable_o(s_byte_enable_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ready_i(s_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference decode: first segment whose masked top nibble equals its base.
  function automatic int ref_slave(input logic [31:0] a);
    for (int k = 0; k < N; k++)
      if ((a[31:28] & MASK[k]) == BASE[k]) return k;
    return -1;
  endfunction

  task automatic rand_sdata();
    s_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic idle_check();
    p_strobe_i = 1'b0;
    s_ready_i  = 4'($urandom());
    rand_sdata();
    @(negedge clk_i);
    chk("idle_ready",  p_ready_o,  0);
    chk("idle_err",    p_err_o,    0);
    chk("idle_busy",   busy_o,     0);
    chk("idle_data",   p_data_o,   0);
    chk("idle_strobe", s_strobe_o, 0);
    tick();
  endtask

  // One transaction; lat = cycle after acceptance when the slave answers (> TO means never).
  task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [31:0] rdata,
                         input int lat, input bit noise);
    int k;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  e_strb;
    logic [3:0]  e_rw;
    logic [3:0]  rdy;
    bit ok, tmo;
    k  = ref_slave(addr);
    wd = $urandom();
    be = 4'($urandom());
    e_strb = '0;
    e_rw   = '0;
    if (k >= 0) begin
      e_strb[k] = 1'b1;
      e_rw[k]   = rw;
    end
    p_strobe_i = 1'b1; p_addr_i = addr; p_rw_i = rw; p_data_i = wd; p_byte_enable_i = be;
    s_ready_i = noise ? 4'($urandom()) : 4'h0;
    rand_sdata();
    @(negedge clk_i);
    chk("acc_strobe", s_strobe_o, e_strb);
    chk("acc_rw",     s_rw_o,     e_rw);
    chk("acc_ready",  p_ready_o,  0);
    chk("acc_busy",   busy_o,     0);
    chk("acc_addr",   s_addr_o,   addr);
    chk("acc_wdata",  s_data_o,   wd);
    chk("acc_be",     s_byte_enable_o, be);
    tick();
    if (k < 0) begin
      p_strobe_i = noise;
      s_ready_i  = 4'($urandom());
      @(negedge clk_i);
      chk("unm_ready",  p_ready_o,  1);
      chk("unm_err",    p_err_o,    1);
      chk("unm_data",   p_data_o,   ERRD);
      chk("unm_busy",   busy_o,     1);
      chk("unm_strobe", s_strobe_o, 0);
      tick();
    end else begin
      for (int c = 1; c <= TO; c++) begin
        p_strobe_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) p_addr_i = $urandom();
        rdy = noise ? 4'($urandom()) : 4'h0;
        rdy[k] = (c == lat);
        s_ready_i = rdy;
        rand_sdata();
        s_data_i[k*32 +: 32] = rdata;
        ok  = (c == lat);
        tmo = (c == TO) && !ok;
        @(negedge clk_i);
        chk("wait_strobe", s_strobe_o, 0);
        chk("wait_rw",     s_rw_o,     0);
        chk("wait_busy",   busy_o,     1);
        chk("wait_ready",  p_ready_o,  ok || tmo);
        chk("wait_err",    p_err_o,    tmo);
        chk("wait_data",   p_data_o,   tmo ? ERRD : rdata);
        tick();
        if (ok || tmo) break;
      end
    end
    // A late ready from the same slave must not produce a completion.
    p_strobe_i = 1'b0;
    s_ready_i  = (k >= 0) ? 4'(1 << k) : 4'hF;
    @(negedge clk_i);
    chk("post_ready", p_ready_o, 0);
    chk("post_busy",  busy_o,    0);
    chk("post_data",  p_data_o,  0);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    rst_i = 1'b1; p_strobe_i = 1'b0; p_addr_i = '0; p_rw_i = 1'b0;
    p_byte_enable_i = '0; p_data_i = '0; s_data_i = '0; s_ready_i = '0;
    tick();
    // Reset cycle: a mapped request and slave readies must leave outputs at zero.
    p_strobe_i = 1'b1; p_addr_i = 32'h0000_0000; p_rw_i = 1'b1; s_ready_i = 4'hF;
    rand_sdata();
    @(negedge clk_i);
    chk("rst_ready",  p_ready_o,  0);
    chk("rst_err",    p_err_o,    0);
    chk("rst_busy",   busy_o,     0);
    chk("rst_strobe", s_strobe_o, 0);
    chk("rst_rw",     s_rw_o,     0);
    chk("rst_data",   p_data_o,   0);
    tick();
    rst_i = 1'b0;
    idle_check();

    run_txn(32'h8000_0010, 1'b0, 32'h1234_5678, 3, 1'b0);   // read slave 1
    run_txn(32'hC000_0004, 1'b1, 32'h0BAD_F00D, 2, 1'b0);   // write slave 2
    run_txn(32'h4000_0000, 1'b0, 32'h0, 1, 1'b0);           // unmapped
    run_txn(32'hF000_0000, 1'b0, 32'h5555_AAAA, 100, 1'b0); // slave 3 silent -> timeout
    run_txn(32'hF000_0040, 1'b0, 32'hCAFE_0001, TO, 1'b1);  // ready on expiry cycle
    run_txn(32'h0000_0020, 1'b1, 32'h7777_0000, 1, 1'b1);   // immediate ready

    // Reset in the middle of a wait.
    p_strobe_i = 1'b1; p_addr_i = 32'hF000_0000; p_rw_i = 1'b0;
    tick();
    p_strobe_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1; s_ready_i = 4'hF;
    @(negedge clk_i);
    chk("mrst_ready",  p_ready_o,  0);
    chk("mrst_err",    p_err_o,    0);
    chk("mrst_busy",   busy_o,     0);
    chk("mrst_strobe", s_strobe_o, 0);
    chk("mrst_data",   p_data_o,   0);
    tick();
    rst_i = 1'b0; s_ready_i = 4'b1000;
    @(negedge clk_i);
    chk("mrst_late_busy",  busy_o,    0);
    chk("mrst_late_ready", p_ready_o, 0);
    tick();
    run_txn(32'h0000_0100, 1'b0, 32'h0101_0101, 2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      run_txn(a, 1'($urandom_range(0, 1)), $urandom(), $urandom_range(1, TO + 3),
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_router.md
DBUS_ROUTER -- requirements
Module: dbus_router

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter N_SLV, default 4, number of slave ports (range 1..8).
REQ-003 SHALL have parameter SEG_BASE, default {4'hF,4'hC,4'h8,4'h0}, per-slave segment base nibble, slave 0 in LSBs.
REQ-004 SHALL have parameter SEG_MASK, default {4'hF,4'hF,4'hC,4'hF}, per-slave segment mask nibble.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum wait cycles (1..65535).
REQ-006 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on error.
REQ-007 clk_i  input  1  sole clock, rising edge.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 p_strobe_i  input  1  one-cycle request pulse from core.
REQ-010 p_addr_i  input  XLEN  request address.
REQ-011 p_rw_i  input  1  1 = write.
REQ-012 p_byte_enable_i  input  XLEN/8  byte lanes.
REQ-013 p_data_i  input  XLEN  write data.
REQ-014 p_data_o  output  XLEN  read data to core.
REQ-015 p_ready_o  output  1  one-cycle completion pulse.
REQ-016 p_err_o  output  1  completion is an error (unmapped or timeout).
REQ-017 busy_o  output  1  transaction outstanding.
REQ-018 s_strobe_o  output  N_SLV  per-slave request pulse.
REQ-019 s_rw_o  output  N_SLV  per-slave write qualifier.
REQ-020 s_addr_o, s_byte_enable_o, s_data_o  output  XLEN, XLEN/8, XLEN  shared, pass-through of p_* inputs.
REQ-021 s_data_i  input  N_SLV*XLEN  slave read data, slave 0 in LSBs.
REQ-022 s_ready_i  input  N_SLV  slave completion.

Function
REQ-023 Decode: slave k SHALL match when (p_addr_i[XLEN-1:XLEN-4] & SEG_MASK[k]) == SEG_BASE[k]; lowest matching index wins; no match = unmapped.
REQ-024 States SHALL be IDLE, WAIT, ERR.
REQ-025 IDLE + p_strobe_i + mapped slave k: s_strobe_o[k]=1 and s_rw_o[k]=p_rw_i in that cycle only (combinational); sel_r<=k, counter<=0, next WAIT.
REQ-026 IDLE + p_strobe_i + unmapped: no s_strobe_o; next ERR.
REQ-027 ERR: p_ready_o=1, p_err_o=1, p_data_o=ERR_DATA for exactly one cycle; next IDLE (unmapped latency = 1 cycle).
REQ-028 WAIT: p_ready_o=s_ready_i[sel_r], p_data_o=s_data_i[sel_r] (combinational); on s_ready_i[sel_r]=1 next IDLE, p_err_o=0.
REQ-029 WAIT without ready: counter increments; when counter==TIMEOUT-1 and no ready, p_ready_o=1, p_err_o=1, p_data_o=ERR_DATA that cycle, next IDLE.
REQ-030 Slave ready and timeout expiry in same cycle: slave completion wins, p_err_o=0.
REQ-031 s_ready_i from non-selected slaves, or any s_ready_i in IDLE/ERR, SHALL be ignored.
REQ-032 p_strobe_i in WAIT or ERR SHALL be dropped: no s_strobe_o, no state change.
REQ-033 busy_o = 1 in WAIT and ERR, 0 in IDLE.
REQ-034 s_strobe_o, s_rw_o SHALL be 0 outside the IDLE acceptance cycle; p_data_o SHALL be 0 in IDLE when not completing.
REQ-035 Counter SHALL be 16 bits, never wraps (leaves WAIT first).

Reset
REQ-036 rst_i SHALL force IDLE, sel_r=0, counter=0 at the next edge, including mid-WAIT; a late slave ready after reset is ignored.
REQ-037 During reset cycle all outputs SHALL be 0: p_ready_o, p_err_o, busy_o, s_strobe_o, s_rw_o, p_data_o.

Verification
REQ-038 Read 0x8000_0010, slave 1 ready 3 cycles later with 0x1234_5678 -> s_strobe_o=4'b0010 one cycle; p_ready_o=1, p_data_o=0x1234_5678, p_err_o=0.
REQ-039 Write 0xC000_0004 -> s_strobe_o=4'b0100, s_rw_o=4'b0100, s_data_o=p_data_i; completes on s_ready_i[2].
REQ-040 Access 0x4000_0000 -> no s_strobe_o; next cycle p_ready_o=1, p_err_o=1, p_data_o=0xDEAD_BEEF.
REQ-041 TIMEOUT=8, slave 3 never ready -> p_ready_o/p_err_o pulse exactly 8 cycles after acceptance; later s_ready_i[3] ignored.
REQ-042 Slave ready in the timeout-expiry cycle -> p_err_o=0, slave data returned; strobe during WAIT -> no s_strobe_o.
REQ-043 rst_i asserted mid-WAIT -> busy_o=0 next cycle; following request to 0x0000_0100 routes to slave 0 normally.
